// File: rtl/pe_mem_if.sv
// Shared-address bus between one LDPC processing element datapath and its
// message/decision memory front-end.
interface pe_mem_if #(
  parameter int MESSAGE_WIDTH  = 5,
  parameter int DECISION_WIDTH = 1,
  parameter int ADDR_WIDTH     = 8
);
  logic [ADDR_WIDTH-1:0]     address;

  logic                      ext_we;
  logic                      ext_cs;
  logic [MESSAGE_WIDTH-1:0]  ext_data_in  [0:2];
  logic [MESSAGE_WIDTH-1:0]  ext_data_out [0:2];

  logic                      int_we       [0:1];
  logic                      int_cs       [0:1];
  logic                      int_rs;
  logic [MESSAGE_WIDTH-1:0]  int_data_in  [0:1];
  logic [MESSAGE_WIDTH-1:0]  int_data_out [0:1];

  logic                      dec_we       [0:1];
  logic                      dec_cs       [0:1];
  logic                      dec_rs;
  logic [DECISION_WIDTH-1:0] dec_data_in  [0:1];
  logic [DECISION_WIDTH-1:0] dec_data_out [0:1];

  modport master (
    output address,
    output ext_we, ext_cs, ext_data_in,
    input  ext_data_out,
    output int_we, int_cs, int_rs, int_data_in,
    input  int_data_out,
    output dec_we, dec_cs, dec_rs, dec_data_in,
    input  dec_data_out
  );

  modport slave (
    input  address,
    input  ext_we, ext_cs, ext_data_in,
    output ext_data_out,
    input  int_we, int_cs, int_rs, int_data_in,
    output int_data_out,
    input  dec_we, dec_cs, dec_rs, dec_data_in,
    output dec_data_out
  );
endinterface

// File: rtl/pe_mem_block.sv
// Memory front-end of one LDPC PE: 3-lane extrinsic RAM plus ping-pong
// intrinsic and hard-decision RAMs, asynchronous read, one-cycle write.
module pe_mem_block #(
  parameter int MESSAGE_WIDTH  = 5,
  parameter int DECISION_WIDTH = 1,
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  pe_mem_if.slave     bus
);

  logic [MESSAGE_WIDTH-1:0]  ext_mem [0:2][0:RAM_DEPTH-1];
  logic [MESSAGE_WIDTH-1:0]  int_mem [0:1][0:RAM_DEPTH-1];
  logic [DECISION_WIDTH-1:0] dec_mem [0:1][0:RAM_DEPTH-1];

  logic                      int_bank_we [0:1];
  logic [MESSAGE_WIDTH-1:0]  int_bank_wd [0:1];
  logic                      dec_bank_we [0:1];
  logic [DECISION_WIDTH-1:0] dec_bank_wd [0:1];

  // Port k and bank k pair up through the same XOR, so the mapping is its own inverse.
  function automatic logic swap_index(input int idx, input logic rs);
    return 1'(idx) ^ rs;
  endfunction

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      int_bank_we[b] = bus.int_cs[swap_index(b, bus.int_rs)] &
                       bus.int_we[swap_index(b, bus.int_rs)];
      int_bank_wd[b] = bus.int_data_in[swap_index(b, bus.int_rs)];
      dec_bank_we[b] = bus.dec_cs[swap_index(b, bus.dec_rs)] &
                       bus.dec_we[swap_index(b, bus.dec_rs)];
      dec_bank_wd[b] = bus.dec_data_in[swap_index(b, bus.dec_rs)];
    end
  end

  // Writes are suppressed during reset; stored contents are left untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (bus.ext_cs && bus.ext_we) begin
        for (int k = 0; k < 3; k++) begin
          ext_mem[k][bus.address] <= bus.ext_data_in[k];
        end
      end
      for (int b = 0; b < 2; b++) begin
        if (int_bank_we[b]) begin
          int_mem[b][bus.address] <= int_bank_wd[b];
        end
        if (dec_bank_we[b]) begin
          dec_mem[b][bus.address] <= dec_bank_wd[b];
        end
      end
    end
  end

  // Reads drive data only for cs=1, we=0 outside reset; no write bypass.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      bus.ext_data_out[k] = '0;
      if (!rst && bus.ext_cs && !bus.ext_we) begin
        bus.ext_data_out[k] = ext_mem[k][bus.address];
      end
    end
    for (int p = 0; p < 2; p++) begin
      bus.int_data_out[p] = '0;
      bus.dec_data_out[p] = '0;
      if (!rst && bus.int_cs[p] && !bus.int_we[p]) begin
        bus.int_data_out[p] = int_mem[swap_index(p, bus.int_rs)][bus.address];
      end
      if (!rst && bus.dec_cs[p] && !bus.dec_we[p]) begin
        bus.dec_data_out[p] = dec_mem[swap_index(p, bus.dec_rs)][bus.address];
      end
    end
  end

endmodule

// File: tb/tb_pe_mem_block.sv
// Randomised and directed bench for pe_mem_block against an array-based
// model of the three storage groups.
module tb_pe_mem_block;
  localparam int MW = 5;
  localparam int DW = 1;
  localparam int AW = 8;
  localparam int D  = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_mem_if #(.MESSAGE_WIDTH(MW), .DECISION_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pe_mem_block #(
    .MESSAGE_WIDTH(MW), .DECISION_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference contents plus "has been written" flags (RAMs start unknown).
  logic [MW-1:0] m_ext [3][D];
  bit            k_ext [3][D];
  logic [MW-1:0] m_int [2][D];
  bit            k_int [2][D];
  logic [DW-1:0] m_dec [2][D];
  bit            k_dec [2][D];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the write rules of the current inputs to the model, then clock.
  task automatic tick();
    int a;
    int b;
    a = int'(bus.address);
    if (!rst) begin
      if (bus.ext_cs && bus.ext_we)
        for (int k = 0; k < 3; k++) begin
          m_ext[k][a] = bus.ext_data_in[k];
          k_ext[k][a] = 1'b1;
        end
      for (int p = 0; p < 2; p++) begin
        if (bus.int_cs[p] && bus.int_we[p]) begin
          b = (p + int'(bus.int_rs)) % 2;
          m_int[b][a] = bus.int_data_in[p];
          k_int[b][a] = 1'b1;
        end
        if (bus.dec_cs[p] && bus.dec_we[p]) begin
          b = (p + int'(bus.dec_rs)) % 2;
          m_dec[b][a] = bus.dec_data_in[p];
          k_dec[b][a] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Compare every output with what the model predicts for the current inputs.
  task automatic check_all(input string tag);
    int a;
    int b;
    a = int'(bus.address);
    for (int k = 0; k < 3; k++) begin
      if (rst || !bus.ext_cs || bus.ext_we)
        chk($sformatf("%s ext%0d idle", tag, k), 32'(bus.ext_data_out[k]), 32'd0);
      else if (k_ext[k][a])
        chk($sformatf("%s ext%0d rd", tag, k), 32'(bus.ext_data_out[k]), 32'(m_ext[k][a]));
    end
    for (int p = 0; p < 2; p++) begin
      b = (p + int'(bus.int_rs)) % 2;
      if (rst || !bus.int_cs[p] || bus.int_we[p])
        chk($sformatf("%s int%0d idle", tag, p), 32'(bus.int_data_out[p]), 32'd0);
      else if (k_int[b][a])
        chk($sformatf("%s int%0d rd", tag, p), 32'(bus.int_data_out[p]), 32'(m_int[b][a]));
      b = (p + int'(bus.dec_rs)) % 2;
      if (rst || !bus.dec_cs[p] || bus.dec_we[p])
        chk($sformatf("%s dec%0d idle", tag, p), 32'(bus.dec_data_out[p]), 32'd0);
      else if (k_dec[b][a])
        chk($sformatf("%s dec%0d rd", tag, p), 32'(bus.dec_data_out[p]), 32'(m_dec[b][a]));
    end
  endtask

  task automatic idle_all();
    bus.ext_we = 1'b0; bus.ext_cs = 1'b0;
    bus.int_rs = 1'b0; bus.dec_rs = 1'b0;
    for (int k = 0; k < 3; k++) bus.ext_data_in[k] = '0;
    for (int p = 0; p < 2; p++) begin
      bus.int_we[p] = 1'b0; bus.int_cs[p] = 1'b0; bus.int_data_in[p] = '0;
      bus.dec_we[p] = 1'b0; bus.dec_cs[p] = 1'b0; bus.dec_data_in[p] = '0;
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [MW-1:0] rexp;

    // Reset state: outputs forced to zero even with read strobes active.
    rst = 1'b1;
    bus.address = '0;
    idle_all();
    tick();
    tick();
    bus.ext_cs = 1'b1;
    for (int p = 0; p < 2; p++) begin bus.int_cs[p] = 1'b1; bus.dec_cs[p] = 1'b1; end
    #1;
    check_all("reset");
    rst = 1'b0;
    idle_all();
    tick();

    // Extrinsic fill, then asynchronous random reads.
    bus.ext_cs = 1'b1; bus.ext_we = 1'b1;
    for (int i = 0; i < D; i++) begin
      bus.address = AW'(i);
      for (int k = 0; k < 3; k++) bus.ext_data_in[k] = MW'(i);
      tick();
    end
    bus.ext_we = 1'b0;
    for (int n = 0; n < 20; n++) begin
      ra = AW'($urandom_range(0, D - 1));
      bus.address = ra;
      rexp = ra[MW-1:0];
      #2;
      for (int k = 0; k < 3; k++)
        chk($sformatf("fill_rd a=%0d lane%0d", ra, k), 32'(bus.ext_data_out[k]), 32'(rexp));
    end

    // Extrinsic gating.
    bus.address = 8'd7; bus.ext_cs = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("gate_cs0 lane%0d", k), 32'(bus.ext_data_out[k]), 32'd0);
    bus.ext_cs = 1'b1; bus.ext_we = 1'b1;
    for (int k = 0; k < 3; k++) bus.ext_data_in[k] = MW'(19 + k);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("gate_we1 lane%0d", k), 32'(bus.ext_data_out[k]), 32'd0);
    tick();
    bus.ext_we = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("gate_rdback lane%0d", k), 32'(bus.ext_data_out[k]), 32'(19 + k));
    bus.ext_cs = 1'b0;

    // Intrinsic bank swap.
    bus.address = 8'd3; bus.int_rs = 1'b0;
    for (int p = 0; p < 2; p++) begin bus.int_cs[p] = 1'b1; bus.int_we[p] = 1'b1; end
    bus.int_data_in[0] = 5'd5; bus.int_data_in[1] = 5'd9;
    tick();
    bus.int_we[0] = 1'b0; bus.int_we[1] = 1'b0;
    #1;
    chk("int rs0 p0", 32'(bus.int_data_out[0]), 32'd5);
    chk("int rs0 p1", 32'(bus.int_data_out[1]), 32'd9);
    bus.int_rs = 1'b1;
    #1;
    chk("int rs1 p0", 32'(bus.int_data_out[0]), 32'd9);
    chk("int rs1 p1", 32'(bus.int_data_out[1]), 32'd5);
    bus.int_we[0] = 1'b1; bus.int_data_in[0] = 5'd12;
    tick();
    bus.int_we[0] = 1'b0; bus.int_rs = 1'b0;
    #1;
    chk("int redirect p0", 32'(bus.int_data_out[0]), 32'd5);
    chk("int redirect p1", 32'(bus.int_data_out[1]), 32'd12);

    // Decision bank swap.
    bus.address = 8'd200; bus.dec_rs = 1'b0;
    for (int p = 0; p < 2; p++) begin bus.dec_cs[p] = 1'b1; bus.dec_we[p] = 1'b1; end
    bus.dec_data_in[0] = 1'b1; bus.dec_data_in[1] = 1'b0;
    tick();
    bus.dec_we[0] = 1'b0; bus.dec_we[1] = 1'b0; bus.dec_rs = 1'b1;
    #1;
    chk("dec rs1 p0", 32'(bus.dec_data_out[0]), 32'd0);
    chk("dec rs1 p1", 32'(bus.dec_data_out[1]), 32'd1);
    idle_all();

    // Reset drops a concurrent write and retains contents.
    bus.address = 8'd10; rst = 1'b1;
    bus.ext_cs = 1'b1; bus.ext_we = 1'b1;
    for (int k = 0; k < 3; k++) bus.ext_data_in[k] = 5'd21;
    for (int p = 0; p < 2; p++) begin bus.int_cs[p] = 1'b1; bus.dec_cs[p] = 1'b1; end
    #1;
    check_all("rst_wr");
    tick();
    bus.ext_we = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("rst_rd lane%0d", k), 32'(bus.ext_data_out[k]), 32'd0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("rst_keep lane%0d", k), 32'(bus.ext_data_out[k]), 32'd10);
    idle_all();

    // Independent intrinsic port enables.
    bus.address = 8'd50;
    for (int p = 0; p < 2; p++) begin bus.int_cs[p] = 1'b1; bus.int_we[p] = 1'b1; end
    bus.int_data_in[0] = 5'd1; bus.int_data_in[1] = 5'd2;
    tick();
    bus.int_cs[1] = 1'b0;
    bus.int_data_in[0] = 5'd20; bus.int_data_in[1] = 5'd21;
    tick();
    bus.int_cs[1] = 1'b1; bus.int_we[0] = 1'b0; bus.int_we[1] = 1'b0;
    #1;
    chk("indep p0", 32'(bus.int_data_out[0]), 32'd20);
    chk("indep p1", 32'(bus.int_data_out[1]), 32'd2);

    // Random traffic over a small address window.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 15) == 0);
      bus.address = AW'($urandom_range(0, 15));
      bus.ext_cs = 1'($urandom); bus.ext_we = 1'($urandom);
      bus.int_rs = 1'($urandom); bus.dec_rs = 1'($urandom);
      for (int k = 0; k < 3; k++) bus.ext_data_in[k] = MW'($urandom);
      for (int p = 0; p < 2; p++) begin
        bus.int_cs[p] = 1'($urandom); bus.int_we[p] = 1'($urandom);
        bus.dec_cs[p] = 1'($urandom); bus.dec_we[p] = 1'($urandom);
        bus.int_data_in[p] = MW'($urandom);
        bus.dec_data_in[p] = DW'($urandom);
      end
      #2;
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pe_mem_block.md
Name: pe_mem_block

Overview:
- Memory front-end of one LDPC decoder processing element (PE).
- Bundles three storage groups behind one shared address bus:
  - an extrinsic-message RAM: 3 lanes, common control;
  - an intrinsic-message RAM: 2 ping-pong banks with bank swap;
  - a hard-decision RAM: 2 ping-pong banks with bank swap.
- The PE datapath writes and reads messages through this block each decode iteration.

Parameters:
- MESSAGE_WIDTH, 5, bit width of extrinsic/intrinsic message words.
- DECISION_WIDTH, 1, bit width of decision words.
- ADDR_WIDTH, 8, address width shared by all RAMs.
- RAM_DEPTH, 1<<ADDR_WIDTH, words per bank.

Ports:
- clk  in  1  single clock; all writes on rising edge.
- rst  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  common address for every bank.
- ext_we  in  1  extrinsic write enable, all 3 lanes.
- ext_cs  in  1  extrinsic chip select, all 3 lanes.
- ext_data_in  in  [0:2] x MESSAGE_WIDTH  per-lane write data.
- ext_data_out  out  [0:2] x MESSAGE_WIDTH  per-lane read data.
- int_we  in  [0:1] x 1  per-port intrinsic write enable.
- int_cs  in  [0:1] x 1  per-port intrinsic chip select.
- int_rs  in  1  intrinsic bank-swap select.
- int_data_in  in  [0:1] x MESSAGE_WIDTH  per-port write data.
- int_data_out  out  [0:1] x MESSAGE_WIDTH  per-port read data.
- dec_we  in  [0:1] x 1  per-port decision write enable.
- dec_cs  in  [0:1] x 1  per-port decision chip select.
- dec_rs  in  1  decision bank-swap select.
- dec_data_in  in  [0:1] x DECISION_WIDTH  per-port write data.
- dec_data_out  out  [0:1] x DECISION_WIDTH  per-port read data.

Behaviour:
- Storage: 3 ext banks, 2 int banks, 2 dec banks, each RAM_DEPTH words. Single-port, shared address. Contents are not initialised.
- Write: at rising clk edge, if rst=0 and cs=1 and we=1, the bank word at address takes data_in. New data is visible on the outputs right after that edge.
- Read: combinational (asynchronous). data_out = mem[address] while cs=1 and we=0. An address change updates data_out within the same cycle, with no clock edge needed.
- Idle/write output: data_out = 0 when cs=0, or when cs=1 and we=1. There is no read-during-write bypass.
- Extrinsic group: ext_we/ext_cs gate all 3 lanes together. Lane k uses ext_data_in[k] and ext_data_out[k].
- Intrinsic port-to-bank mapping: port k accesses bank (k XOR int_rs). It uses int_we[k], int_cs[k], int_data_in[k] and int_data_out[k].
  - int_rs=0: port0→bank0, port1→bank1.
  - int_rs=1: port0→bank1, port1→bank0.
  - The mapping is a permutation, so two ports can never hit one bank in the same cycle.
- Decision group: same mapping rule as intrinsic, using dec_rs.
- rs is combinational. Toggling it swaps read data immediately and redirects writes from the next edge onward.
- Reset: while rst=1 at an edge, all writes are suppressed. While rst=1, all data_out are forced to 0. RAM contents are retained, not cleared.
- Reset mid-operation: a write coinciding with rst=1 is dropped. Operation resumes on the first edge with rst=0.
- Address wrap: address covers 0..RAM_DEPTH-1 exactly. There is no out-of-range case.
- No output registers; zero read latency; one-cycle write.

Test Plan:
- Ext fill and readback: for i=0..255 write ext_data_in[0..2]=i[4:0] at address=i, then issue 20 random reads with cs=1, we=0 → all three ext_data_out equal address[4:0] within 2 time units of the address change.
- Ext gating: address=7 holding 7, cs=0 → ext_data_out all 0. Then cs=1, we=1 → outputs 0. The write stores new data, and a read afterwards returns it.
- Intrinsic swap: with int_rs=0, write port0=5 and port1=9 at address 3. Set int_rs=1 → int_data_out[0]=9 and int_data_out[1]=5. A port0 write of 12 with rs=1 lands in bank1, so at rs=0 int_data_out[1]=12.
- Decision swap: with dec_rs=0, write dec port0=1 and port1=0 at address 200. Set dec_rs=1 → dec_data_out[0]=0 and dec_data_out[1]=1.
- Reset: hold rst=1 while attempting ext write 21 at address 10 → all outputs 0 and the write is dropped. After rst=0, a read of address 10 returns the pre-reset content.
- Independent port enables: int_cs[0]=1 and int_cs[1]=0 with both we=1 → only the bank mapped to port0 is updated.
